// File: rtl/des_decrypt_128bit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_decrypt_128bit_if : request/response bundle for the 128-bit DES       |
// |                         decryptor (two 64-bit lanes).                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface des_decrypt_128bit_if #(
    parameter int CNT_W = 5
);
    logic               Start;
    logic [127:0]       Cirphertext_in;
    logic [127:0]       Key_in;
    logic [127:0]       Plaintext_out;
    logic               Busy;
    logic               Done;
    logic [CNT_W-1:0]   Counter_machine;

    modport master (
        output Start, Cirphertext_in, Key_in,
        input  Plaintext_out, Busy, Done, Counter_machine
    );

    modport slave (
        input  Start, Cirphertext_in, Key_in,
        output Plaintext_out, Busy, Done, Counter_machine
    );
endinterface
`default_nettype wire

// File: rtl/des_decrypt_128bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_decrypt_128bit : iterative dual-lane DES decryptor, one round per     |
// |                      clock per lane, plaintext returned with a Done pulse.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module des_decrypt_128bit #(
    parameter int ROUNDS = 16,
    parameter int CNT_W  = 5
) (
    input wire                   Clk,
    input wire                   Reset,
    des_decrypt_128bit_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Tables use FIPS bit numbering: position 1 is the MSB of the input word.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = k[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        int          e;
        int          sval;
        x = '0;
        s = '0;
        y = '0;
        // E expansion: each 6-bit group g takes input bits 4g..4g+5 (1-based), wrapping mod 32
        for (int i = 0; i < 48; i++) begin
            e = (4 * (i / 6) + (i % 6) + 31) % 32;
            x[6'(47 - i)] = r[5'(31 - e)];
        end
        x = x ^ k;
        for (int g = 0; g < 8; g++) begin
            b    = x[6'(47 - 6 * g) -: 6];
            sval = SBOX[g][int'({b[5], b[0], b[4:1]})];
            s[5'(31 - 4 * g) -: 4] = sval[3:0];
        end
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
        return y;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [127:0]     pt_q, pt_d;
    logic [31:0]      l_q [2];
    logic [31:0]      l_d [2];
    logic [31:0]      r_q [2];
    logic [31:0]      r_d [2];
    logic [27:0]      c_q [2];
    logic [27:0]      c_d [2];
    logic [27:0]      d_q [2];
    logic [27:0]      d_d [2];

    logic [63:0]      w_ip [2];
    logic [55:0]      w_cd [2];
    logic [31:0]      w_f  [2];
    logic [63:0]      w_fp [2];
    logic             w_rot1;

    // Lane 1 = bits [127:64], lane 0 = bits [63:0]
    for (genvar ln = 0; ln < 2; ln++) begin : g_lane
        assign w_ip[ln] = ip_perm(bus.Cirphertext_in[64*ln +: 64]);
        assign w_cd[ln] = pc1_perm(bus.Key_in[64*ln +: 64]);
        assign w_f[ln]  = f_func(r_q[ln], pc2_perm({c_q[ln], d_q[ln]}));
        assign w_fp[ln] = fp_perm({r_q[ln], l_q[ln]});
    end

    // Reverse key schedule: single-step right rotations mirror encryption rounds 16, 9, 2, 1
    assign w_rot1 = (cnt_q == CNT_W'(1))  || (cnt_q == CNT_W'(8)) ||
                    (cnt_q == CNT_W'(15)) || (cnt_q == CNT_W'(16));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pt_d    = pt_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    for (int ln = 0; ln < 2; ln++) begin
                        l_d[ln] = w_ip[ln][63:32];
                        r_d[ln] = w_ip[ln][31:0];
                        c_d[ln] = w_cd[ln][55:28];
                        d_d[ln] = w_cd[ln][27:0];
                    end
                    cnt_d   = CNT_W'(1);
                    busy_d  = 1'b1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                for (int ln = 0; ln < 2; ln++) begin
                    l_d[ln] = r_q[ln];
                    r_d[ln] = l_q[ln] ^ w_f[ln];
                    c_d[ln] = w_rot1 ? {c_q[ln][0], c_q[ln][27:1]} : {c_q[ln][1:0], c_q[ln][27:2]};
                    d_d[ln] = w_rot1 ? {d_q[ln][0], d_q[ln][27:1]} : {d_q[ln][1:0], d_q[ln][27:2]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ROUNDS)) state_d = S_FINAL;
            end
            S_FINAL: begin
                pt_d    = {w_fp[1], w_fp[0]};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pt_q    <= '0;
            l_q     <= '{default: '0};
            r_q     <= '{default: '0};
            c_q     <= '{default: '0};
            d_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pt_q    <= pt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    assign bus.Plaintext_out   = pt_q;
    assign bus.Busy            = busy_q;
    assign bus.Done            = done_q;
    assign bus.Counter_machine = cnt_q;
endmodule
`default_nettype wire
